cond_execute_stage: RTL and testbench
=====================================

COND_EXECUTE_STAGE -- requirements
Module: cond_execute_stage

Interface
REQ-001 The block SHALL expose the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- StallE  in  1  hold the execute register
- FlushE  in  1  replace the execute register contents with a bubble
- RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD, PlusOneD  in  1 each  decode-stage control
- ALUControlD  in  4  decode-stage ALU operation
- FlagWD  in  2  decode-stage flag-write enables: [1] updates N,Z; [0] updates C,V
- CondD  in  4  decode-stage condition field
- ALUFlags  in  4  live ALU result flags {N,Z,C,V} for the instruction in execute
- RegWriteE, MemWriteE, PCSrcE  out  1 each  condition-gated execute controls
- BranchTakenE  out  1  BranchE AND CondExE AND ValidE
- MemToRegE, ALUSrcE, PlusOneE  out  1 each  registered, ungated
- ALUControlE  out  4  registered ALU operation
- CondExE  out  1  condition passed for the valid instruction in execute
- FlagsQ  out  4  architectural {N,Z,C,V} register
REQ-002 Clock and reset SHALL be one clock, clk, with a synchronous, active-low reset, reset_n; no other clock or asynchronous path.

Function
REQ-003 The execute register SHALL hold ValidE, all D-stage controls, FlagWE[1:0] and CondE[3:0].
- Each rising edge with StallE=0 and FlushE=0 loads the D-stage values and sets ValidE=1.
REQ-004 StallE=1 with FlushE=0 SHALL hold every execute-register bit.
REQ-005 FlushE=1 SHALL load a bubble regardless of StallE, so flush wins when both are asserted.
- A bubble clears ValidE and every control bit, including ALUControlE, to 0, and sets CondE=1110.
REQ-006 CondExE SHALL equal ValidE AND cond(CondE, FlagsQ), evaluated combinationally. cond() is defined as:
- 0000 EQ Z
- 0001 NE !Z
- 0010 CS C
- 0011 CC !C
- 0100 MI N
- 0101 PL !N
- 0110 VS V
- 0111 VC !V
- 1000 HI C&!Z
- 1001 LS !C|Z
- 1010 GE N==V
- 1011 LT N!=V
- 1100 GT !Z&(N==V)
- 1101 LE Z|(N!=V)
- 1110 AL 1
- 1111 1 (unconditional)
REQ-007 RegWriteE, MemWriteE and PCSrcE SHALL each equal their registered bit AND CondExE.
- All other outputs pass through ungated.
REQ-008 FlagsQ[3:2] SHALL load ALUFlags[3:2] on an edge where StallE=0 and FlagWE[1]=1 and CondExE=1.
REQ-009 FlagsQ[1:0] SHALL load ALUFlags[1:0] on an edge where StallE=0 and FlagWE[0]=1 and CondExE=1.
- Otherwise FlagsQ holds.
- A flags update and a simultaneous flush SHALL both take effect: flags are written by the departing instruction, and the register becomes a bubble.
REQ-010 Flag-register latency SHALL be one cycle.
- Condition evaluation uses FlagsQ only, with no ALUFlags bypass.
- An instruction entering execute on the edge that follows a flag-setting instruction sees the updated flags.
REQ-011 A stalled instruction SHALL NOT write flags while stalled.
- It writes exactly once, on the edge where it leaves execute.
REQ-012 Input ALUControlD values containing X/Z SHALL be registered as-is.
- After reset, or after a bubble is loaded, ALUControlE SHALL be 0000.

Reset
REQ-013 On an edge with reset_n=0, the block SHALL clear ValidE, every execute-register control bit, ALUControlE and FlagsQ to 0, and set CondE=1110.
- Reset has priority over StallE and FlushE.
REQ-014 While reset_n=0 and after the edge, all outputs SHALL be 0.
- CondExE=0 because ValidE=0.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction.
- No flag write occurs on the reset edge.

Verification
REQ-016 Reset: FlagsQ=1111 beforehand, reset_n=0 for one edge -> FlagsQ=0000, all outputs 0, ALUControlE=0000.
REQ-017 Flag set then conditional execute:
- Step 1: SUBS (FlagWD=11, CondD=1110), ALUFlags=0100.
- Step 2: next edge, FlagsQ=0100; load RegWriteD=1, CondD=0000 (EQ) -> CondExE=1, RegWriteE=1.
- Step 3: same instruction with CondD=0001 (NE) -> CondExE=0, RegWriteE=0, FlagsQ unchanged.
REQ-018 Partial flag write: FlagsQ=0011, FlagWE=10, ALUFlags=1100, CondE=1110 -> FlagsQ=1111 after the edge.
REQ-019 Stall and flush:
- StallE=1 for 3 edges with a flag-setting instruction in execute -> FlagsQ unchanged; execute register unchanged.
- StallE=0 -> exactly one flag write.
- StallE=1 and FlushE=1 together -> bubble loaded (ValidE=0, CondExE=0).
REQ-020 Branch gating: BranchD=PCSrcD=1 with CondD=1011 (LT).
- FlagsQ=1000 -> BranchTakenE=1, PCSrcE=1.
- FlagsQ=1001 -> BranchTakenE=0, PCSrcE=0.
- Bubble with FlagsQ=any and CondE=1110 -> BranchTakenE=0.

Source files
------------

// File: rtl/cond_execute_stage.sv
// Execute-stage pipeline register with condition evaluation and the architectural NZCV register.
// Write-type controls are gated by the condition result. Flags are written by the instruction leaving execute.
module cond_execute_stage (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       MemToRegD,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       ALUSrcD,
    input  logic       PlusOneD,
    input  logic [3:0] ALUControlD,
    input  logic [1:0] FlagWD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlags,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       PCSrcE,
    output logic       BranchTakenE,
    output logic       MemToRegE,
    output logic       ALUSrcE,
    output logic       PlusOneE,
    output logic [3:0] ALUControlE,
    output logic       CondExE,
    output logic [3:0] FlagsQ
);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       pcsrc;
        logic       alusrc;
        logic       plusone;
        logic [3:0] aluctl;
        logic [1:0] flagw;
        logic [3:0] cond;
    } ex_reg_t;

    // Bubble: everything cleared, condition forced to AL so it is harmless if ever re-validated.
    localparam ex_reg_t BUBBLE = ex_reg_t'({14'b0, 4'b1110});

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    logic    cond_ok;
    logic    wr_nz;
    logic    wr_cv;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = !cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cf & !z;
            4'b1001: cond_pass = !cf | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    always_comb begin
        ex_d          = ex_q;
        ex_d.valid    = 1'b1;
        ex_d.regwrite = RegWriteD;
        ex_d.memwrite = MemWriteD;
        ex_d.memtoreg = MemToRegD;
        ex_d.branch   = BranchD;
        ex_d.pcsrc    = PCSrcD;
        ex_d.alusrc   = ALUSrcD;
        ex_d.plusone  = PlusOneD;
        ex_d.aluctl   = ALUControlD;
        ex_d.flagw    = FlagWD;
        ex_d.cond     = CondD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            ex_q <= BUBBLE;
        else if (FlushE)
            ex_q <= BUBBLE;
        else if (!StallE)
            ex_q <= ex_d;
    end

    // Condition sees only the registered flags; there is no ALUFlags bypass.
    assign cond_ok = cond_pass(ex_q.cond, FlagsQ);
    assign CondExE = ex_q.valid & cond_ok;

    // A flush does not cancel the departing instruction's flag write; a stall does.
    assign wr_nz = !StallE & CondExE & ex_q.flagw[1];
    assign wr_cv = !StallE & CondExE & ex_q.flagw[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            FlagsQ <= 4'b0000;
        end else begin
            if (wr_nz) FlagsQ[3:2] <= ALUFlags[3:2];
            if (wr_cv) FlagsQ[1:0] <= ALUFlags[1:0];
        end
    end

    assign RegWriteE    = ex_q.regwrite & CondExE;
    assign MemWriteE    = ex_q.memwrite & CondExE;
    assign PCSrcE       = ex_q.pcsrc & CondExE;
    assign BranchTakenE = ex_q.branch & CondExE;
    assign MemToRegE    = ex_q.memtoreg;
    assign ALUSrcE      = ex_q.alusrc;
    assign PlusOneE     = ex_q.plusone;
    assign ALUControlE  = ex_q.aluctl;

endmodule

// File: tb/tb_cond_execute_stage.sv
// Directed scenarios plus randomized traffic for cond_execute_stage, checked against a
// cycle-level behavioural model of the execute register and flags.
module tb_cond_execute_stage;

    typedef struct packed {
        logic       regwrite, memwrite, memtoreg, branch, pcsrc, alusrc, plusone;
        logic [3:0] aluctl;
        logic [1:0] flagw;
        logic [3:0] cond;
    } dreq_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       StallE = 1'b0, FlushE = 1'b0;
    logic [3:0] ALUFlags = 4'b0;
    dreq_t      dreq = '0;

    logic       RegWriteE, MemWriteE, PCSrcE, BranchTakenE, MemToRegE, ALUSrcE, PlusOneE, CondExE;
    logic [3:0] ALUControlE, FlagsQ;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cond_execute_stage dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(dreq.regwrite), .MemWriteD(dreq.memwrite), .MemToRegD(dreq.memtoreg),
        .BranchD(dreq.branch), .PCSrcD(dreq.pcsrc), .ALUSrcD(dreq.alusrc), .PlusOneD(dreq.plusone),
        .ALUControlD(dreq.aluctl), .FlagWD(dreq.flagw), .CondD(dreq.cond), .ALUFlags(ALUFlags),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
        .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE), .PlusOneE(PlusOneE), .ALUControlE(ALUControlE),
        .CondExE(CondExE), .FlagsQ(FlagsQ)
    );

    // Reference model: the instruction sitting in execute and the architectural flags.
    dreq_t      m_e;
    logic       m_valid;
    logic [3:0] m_flags;

    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic m_exec();
        return m_valid && passes(m_e.cond, m_flags);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_e     <= '0;
            m_e.cond <= 4'b1110;
            m_flags <= 4'b0;
        end else begin
            if (!StallE && m_exec()) begin
                if (m_e.flagw[1]) m_flags[3:2] <= ALUFlags[3:2];
                if (m_e.flagw[0]) m_flags[1:0] <= ALUFlags[1:0];
            end
            if (FlushE) begin
                m_valid  <= 1'b0;
                m_e      <= '0;
                m_e.cond <= 4'b1110;
            end else if (!StallE) begin
                m_valid <= 1'b1;
                m_e     <= dreq;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all();
        logic cx;
        cx = m_exec();
        chk("CondExE", CondExE, cx);
        chk("RegWriteE", RegWriteE, m_e.regwrite & cx);
        chk("MemWriteE", MemWriteE, m_e.memwrite & cx);
        chk("PCSrcE", PCSrcE, m_e.pcsrc & cx);
        chk("BranchTakenE", BranchTakenE, m_e.branch & cx);
        chk("passthru", {MemToRegE, ALUSrcE, PlusOneE, ALUControlE},
            {m_e.memtoreg, m_e.alusrc, m_e.plusone, m_e.aluctl});
        chk("FlagsQ", FlagsQ, m_flags);
    endtask

    task automatic step(input logic st, input logic fl, input logic [3:0] af);
        StallE = st; FlushE = fl; ALUFlags = af;
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic dreq_t subs();
        dreq_t d;
        d = '0; d.flagw = 2'b11; d.cond = 4'b1110;
        return d;
    endfunction

    initial begin
        reset_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        reset_n = 1'b1;

        // Reset clears flags that were all set
        dreq = subs(); step(0, 0, 4'h0);
        dreq = '0; dreq.cond = 4'b1110; step(0, 0, 4'hf);
        chk("pre_reset_flags", FlagsQ, 4'b1111);
        dreq = subs(); dreq.regwrite = 1'b1; dreq.aluctl = 4'hb; dreq.alusrc = 1'b1;
        StallE = 1'b1; reset_n = 1'b0; step(1, 1, 4'h0);
        chk("reset_flags", FlagsQ, 4'b0000);
        chk("reset_outs", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE, MemToRegE, ALUSrcE,
                           PlusOneE, ALUControlE, CondExE}, 12'h0);
        reset_n = 1'b1;

        // Flag set, then EQ executes and NE does not
        dreq = subs(); step(0, 0, 4'h0);
        dreq = '0; dreq.regwrite = 1'b1; dreq.cond = 4'b0000; step(0, 0, 4'b0100);
        chk("eq_flags", FlagsQ, 4'b0100);
        chk("eq_condex", CondExE, 1'b1);
        chk("eq_regwrite", RegWriteE, 1'b1);
        dreq.cond = 4'b0001; step(0, 0, 4'h0);
        chk("ne_condex", CondExE, 1'b0);
        chk("ne_regwrite", RegWriteE, 1'b0);
        chk("ne_flags", FlagsQ, 4'b0100);

        // Partial flag write: only N,Z updated
        dreq = subs(); step(0, 0, 4'h0);
        dreq = subs(); dreq.flagw = 2'b10; step(0, 0, 4'b0011);
        chk("partial_pre", FlagsQ, 4'b0011);
        dreq = '0; dreq.cond = 4'b1110; step(0, 0, 4'b1100);
        chk("partial_post", FlagsQ, 4'b1111);

        // Stall holds the flag writer; release writes once; stall+flush gives a bubble
        dreq = subs(); dreq.regwrite = 1'b1; step(0, 0, 4'h0);
        dreq = '0; dreq.cond = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4'b1010 ^ 4'(i));
            chk("stall_flags", FlagsQ, 4'b1111);
            chk("stall_hold", RegWriteE, 1'b1);
        end
        step(0, 0, 4'b1010);
        chk("unstall_flags", FlagsQ, 4'b1010);
        step(1, 1, 4'b0101);
        chk("stallflush_condex", CondExE, 1'b0);
        chk("stallflush_flags", FlagsQ, 4'b1010);

        // Branch gating on LT
        dreq = subs(); step(0, 0, 4'h0);
        dreq = '0; dreq.branch = 1'b1; dreq.pcsrc = 1'b1; dreq.cond = 4'b1011; step(0, 0, 4'b1000);
        chk("lt_taken", BranchTakenE, 1'b1);
        chk("lt_pcsrc", PCSrcE, 1'b1);
        dreq = subs(); step(0, 0, 4'h0);
        dreq = '0; dreq.branch = 1'b1; dreq.pcsrc = 1'b1; dreq.cond = 4'b1011; step(0, 0, 4'b1001);
        chk("ge_taken", BranchTakenE, 1'b0);
        chk("ge_pcsrc", PCSrcE, 1'b0);
        step(0, 1, 4'h0);
        chk("bubble_taken", BranchTakenE, 1'b0);
        chk("bubble_aluctl", ALUControlE, 4'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            dreq = dreq_t'($urandom);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
